// File: rtl/audio_rec_pkg.sv
// rtl/audio_rec_pkg.sv - shared constants for the audio record/playback sequencer
package audio_rec_pkg;

  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 2000;
  localparam int AW_DEF    = 11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REC   = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_FETCH = 2'd3;

endpackage

// File: rtl/audio_rec_ctrl.sv
// rtl/audio_rec_ctrl.sv - record/playback sequencer driving an external single-port sample RAM
module audio_rec_ctrl
  import audio_rec_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iSTART,
  input  logic          iSTOP,
  input  logic          iMODE,
  input  logic          iLOOP,
  input  logic          iSAMPLE_STB,
  input  logic [DW-1:0] iAUD_IN,
  output logic [AW-1:0] oMEM_ADDR,
  output logic          oMEM_WE,
  output logic [DW-1:0] oMEM_WDATA,
  input  logic [DW-1:0] iMEM_RDATA,
  output logic [DW-1:0] oAUD_OUT,
  output logic [AW-1:0] oLEN,
  output logic [1:0]    oSTATE,
  output logic          oDONE,
  output logic          oOVR
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] aud_out_q, aud_out_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          wait_q, wait_d;
  // fin_q: final write/load just issued; leave for IDLE on the next cycle
  logic          fin_q, fin_d;
  logic [AW-1:0] addr_inc;

  assign addr_inc = addr_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    aud_out_d   = aud_out_q;
    done_d      = 1'b0;
    ovr_d       = ovr_q;
    wait_d      = 1'b0;
    fin_d       = 1'b0;

    if (state_q != ST_IDLE && iSTOP) begin
      state_d   = ST_IDLE;
      aud_out_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iSTART && !iSTOP) begin
            if (iMODE) begin
              state_d = ST_REC;
              addr_d  = '0;
              len_d   = '0;
              ovr_d   = 1'b0;
            end else if (len_q != '0) begin
              state_d = ST_PLAY;
              addr_d  = '0;
              ovr_d   = 1'b0;
            end
          end
        end
        ST_REC: begin
          if (fin_q) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            aud_out_d = '0;
          end else if (iSAMPLE_STB) begin
            mem_addr_d  = addr_q;
            mem_wdata_d = iAUD_IN;
            mem_we_d    = 1'b1;
            addr_d      = addr_inc;
            len_d       = addr_inc;
            fin_d       = (addr_q == LAST_ADDR);
          end
        end
        ST_PLAY: begin
          if (fin_q) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            aud_out_d = '0;
          end else if (iSAMPLE_STB) begin
            mem_addr_d = addr_q;
            state_d    = ST_FETCH;
          end
        end
        default: begin
          if (iSAMPLE_STB) ovr_d = 1'b1;
          // first FETCH cycle covers the RAM's registered read
          if (!wait_q) begin
            wait_d = 1'b1;
          end else begin
            aud_out_d = iMEM_RDATA;
            state_d   = ST_PLAY;
            if (addr_inc == len_q && iLOOP) begin
              addr_d = '0;
            end else begin
              addr_d = addr_inc;
              fin_d  = (addr_inc == len_q);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      aud_out_q   <= '0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      wait_q      <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      aud_out_q   <= aud_out_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      wait_q      <= wait_d;
      fin_q       <= fin_d;
    end
  end

  assign oSTATE     = state_q;
  assign oMEM_ADDR  = mem_addr_q;
  assign oMEM_WE    = mem_we_q;
  assign oMEM_WDATA = mem_wdata_q;
  assign oAUD_OUT   = aud_out_q;
  assign oLEN       = len_q;
  assign oDONE      = done_q;
  assign oOVR       = ovr_q;

endmodule

// File: tb/tb_audio_rec_ctrl.sv
// tb/tb_audio_rec_ctrl.sv - directed self-checking bench for audio_rec_ctrl with a sync-read RAM model
module tb_audio_rec_ctrl;

  localparam int DW    = 16;
  localparam int DEPTH = 2000;
  localparam int AW    = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, mode = 1'b0, loop_en = 1'b0, stb = 1'b0;
  logic [DW-1:0] aud_in = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata, aud_out;
  logic [AW-1:0] len;
  logic [1:0]    state;
  logic          done, ovr;

  logic [DW-1:0] ram [0:DEPTH-1];
  int            done_cnt = 0;
  int            we_cnt = 0;
  int            last_wa = -1;
  int            n_tests = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  audio_rec_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iSTOP(stop), .iMODE(mode),
    .iLOOP(loop_en), .iSAMPLE_STB(stb), .iAUD_IN(aud_in),
    .oMEM_ADDR(mem_addr), .oMEM_WE(mem_we), .oMEM_WDATA(mem_wdata),
    .iMEM_RDATA(mem_rdata), .oAUD_OUT(aud_out), .oLEN(len), .oSTATE(state),
    .oDONE(done), .oOVR(ovr)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_cnt        <= we_cnt + 1;
      last_wa       <= int'(mem_addr);
    end
    mem_rdata <= ram[mem_addr];
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic m, input logic with_stop);
    @(negedge clk);
    start = 1'b1; mode = m; stop = with_stop;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic rec_strobe(input logic [DW-1:0] d);
    @(negedge clk);
    stb = 1'b1; aud_in = d;
    @(negedge clk);
    stb = 1'b0;
    cycles(3);
  endtask

  task automatic play_strobe(input logic [DW-1:0] prev, input logic [DW-1:0] exp);
    @(negedge clk);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    check("play_fetch_state", 32'(state), 32'd3);
    @(negedge clk);
    check("play_out_early", 32'(aud_out), 32'(prev));
    @(negedge clk);
    check("play_out", 32'(aud_out), 32'(exp));
  endtask

  initial begin
    cycles(2);
    check("rst_state", 32'(state), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_out", 32'(aud_out), 32'd0);
    check("rst_len", 32'(len), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    rst_n = 1'b1;

    // play request with nothing recorded
    do_start(1'b0, 1'b0);
    check("play_len0_idle", 32'(state), 32'd0);

    // record five samples then abort
    do_start(1'b1, 1'b0);
    check("rec_state", 32'(state), 32'd1);
    @(negedge clk);
    stb = 1'b1; aud_in = 16'h0101;
    @(negedge clk);
    stb = 1'b0;
    check("rec_we", 32'(mem_we), 32'd1);
    check("rec_addr0", 32'(mem_addr), 32'd0);
    check("rec_wdata0", 32'(mem_wdata), 32'h0101);
    @(negedge clk);
    check("rec_we_one_cycle", 32'(mem_we), 32'd0);
    cycles(2);
    for (int k = 2; k <= 5; k++) rec_strobe(DW'(k * 16'h0101));
    do_stop();
    check("rec_stop_idle", 32'(state), 32'd0);
    check("rec_stop_len", 32'(len), 32'd5);
    check("rec_stop_nodone", 32'(done_cnt), 32'd0);
    for (int k = 0; k < 5; k++) check("rec_ram", 32'(ram[k]), 32'((k + 1) * 16'h0101));

    // play once, natural end
    loop_en = 1'b0;
    do_start(1'b0, 1'b0);
    check("play_state", 32'(state), 32'd2);
    for (int k = 1; k <= 5; k++) play_strobe(DW'((k - 1) * 16'h0101), DW'(k * 16'h0101));
    check("play_done_early", 32'(done_cnt), 32'd0);
    @(negedge clk);
    check("play_end_idle", 32'(state), 32'd0);
    check("play_done_pulse", 32'(done), 32'd1);
    check("play_end_silence", 32'(aud_out), 32'd0);
    @(negedge clk);
    check("play_done_once", 32'(done_cnt), 32'd1);

    // loop playback over three samples
    do_start(1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) rec_strobe(DW'(k));
    do_stop();
    check("loop_len", 32'(len), 32'd3);
    loop_en = 1'b1;
    do_start(1'b0, 1'b0);
    begin
      logic [DW-1:0] prev;
      prev = '0;
      for (int k = 0; k < 7; k++) begin
        play_strobe(prev, DW'((k % 3) + 1));
        prev = DW'((k % 3) + 1);
      end
    end
    cycles(3);
    check("loop_no_done", 32'(done_cnt), 32'd1);
    check("loop_still_play", 32'(state), 32'd2);
    do_stop();
    check("loop_stop_idle", 32'(state), 32'd0);
    check("loop_stop_silence", 32'(aud_out), 32'd0);

    // strobe during FETCH is lost and flagged
    do_start(1'b0, 1'b0);
    @(negedge clk);
    stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stb = 1'b0;
    check("ovr_set", 32'(ovr), 32'd1);
    cycles(3);
    do_stop();
    check("ovr_sticky", 32'(ovr), 32'd1);
    do_start(1'b0, 1'b0);
    check("ovr_clear_on_start", 32'(ovr), 32'd0);
    do_stop();

    // start and stop together
    do_start(1'b1, 1'b1);
    check("start_stop_idle", 32'(state), 32'd0);
    check("start_stop_len", 32'(len), 32'd3);

    // fill the whole RAM plus three extra strobes
    loop_en = 1'b0;
    we_cnt = 0;
    do_start(1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 3; i++) rec_strobe(DW'(16'h4000 + i));
    check("full_idle", 32'(state), 32'd0);
    check("full_len", 32'(len), 32'd2000);
    check("full_done", 32'(done_cnt), 32'd2);
    check("full_last_addr", 32'(last_wa), 32'd1999);
    check("full_writes", 32'(we_cnt), 32'd2000);
    check("full_ram0", 32'(ram[0]), 32'h4000);
    check("full_ram_last", 32'(ram[1999]), 32'(16'h4000 + 1999));

    // asynchronous reset in the middle of a record
    do_start(1'b1, 1'b0);
    @(negedge clk);
    stb = 1'b1; aud_in = 16'hBEEF;
    @(posedge clk);
    #2;
    stb = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_wdata", 32'(mem_wdata), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_len", 32'(len), 32'd0);
    check("arst_out", 32'(aud_out), 32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_rec_ctrl.md
# audio_rec_ctrl

Record/playback sequencer for the audio recorder. Owns the single-port sample RAM (`sample_ram`, external), the write address and the read address. In record mode it writes one codec sample per frame strobe. In playback mode it fetches one sample per frame strobe and presents it to the audio converter's output register. It sits between the audio converter (`AUD_inL`/`AUD_outL` path) and the sample RAM, driven by user controls (KEY/SW).

## Interface
- `DW`, 16, sample width
- `DEPTH`, 2000, sample RAM depth in words
- `AW`, 11, address width (`2**AW >= DEPTH`)
- `iCLK` in 1: system clock (50 MHz); one clock; all logic on its rising edge
- `iRST_N` in 1: reset, asynchronous, active-low
- `iSTART` in 1: one-cycle pulse, begin the operation selected by `iMODE`
- `iSTOP` in 1: one-cycle pulse, abort the current operation
- `iMODE` in 1: 1 = record, 0 = play; sampled only on `iSTART`
- `iLOOP` in 1: playback wraps to address 0 at end instead of stopping; level, sampled at end of data
- `iSAMPLE_STB` in 1: one-cycle pulse per LR frame, already synchronised to `iCLK`
- `iAUD_IN` in DW: codec input sample, stable while `iSAMPLE_STB` is high
- `oMEM_ADDR` out AW: RAM address
- `oMEM_WE` out 1: RAM write enable
- `oMEM_WDATA` out DW: RAM write data
- `iMEM_RDATA` in DW: RAM read data, one-cycle synchronous read latency
- `oAUD_OUT` out DW: playback sample to the converter
- `oLEN` out AW: number of valid recorded samples
- `oSTATE` out 2: 0 IDLE, 1 REC, 2 PLAY, 3 FETCH
- `oDONE` out 1: one-cycle pulse on natural completion
- `oOVR` out 1: sticky flag, strobe lost; cleared on `iSTART`

## Operation
- **IDLE**
  - `oMEM_WE` = 0.
  - `iSTART` with `iMODE`=1: go to REC; address = 0; `oLEN` = 0; `oOVR` = 0.
  - `iSTART` with `iMODE`=0 and `oLEN` != 0: go to PLAY; address = 0; `oOVR` = 0.
  - `iSTART` with `iMODE`=0 and `oLEN` == 0: ignored; stay in IDLE.
- **REC**
  - On `iSAMPLE_STB`: register `oMEM_ADDR` = addr, `oMEM_WDATA` = `iAUD_IN`, `oMEM_WE` = 1 for exactly one cycle; addr++; `oLEN` = addr+1.
  - After the write to address DEPTH-1: go to IDLE and pulse `oDONE`. Recording never wraps.
- **PLAY**
  - On `iSAMPLE_STB`: register `oMEM_ADDR` = addr; go to FETCH.
- **FETCH** (1 cycle wait, then load)
  - Load `oAUD_OUT` from `iMEM_RDATA`; addr++.
  - If the new addr == `oLEN`:
    - `iLOOP`=1: addr = 0, go to PLAY.
    - `iLOOP`=0: go to IDLE and pulse `oDONE`.
  - Otherwise go to PLAY.
- **`iSTOP`** in any non-IDLE state:
  - Go to IDLE next cycle, deassert `oMEM_WE`, no `oDONE`.
  - REC: `oLEN` keeps the samples already written.
  - PLAY/FETCH: in-flight fetch is discarded.
- **Priority and lost strobes**
  - `iSTOP` beats `iSTART`, `iSAMPLE_STB` and end-of-data in the same cycle.
  - `iSTART` outside IDLE is ignored.
  - `iSAMPLE_STB` in FETCH is dropped and sets `oOVR`.
- **`oAUD_OUT`**: forced to 0 (silence) on entry to IDLE. Holds its value between playback loads.
- **Arithmetic**: addresses are unsigned AW-bit; comparisons against DEPTH-1 and `oLEN` are exact; no modulo-2^AW wrap is ever used.

## Timing
- **Reset values**: state IDLE, all outputs 0 (`oMEM_ADDR`, `oMEM_WE`, `oMEM_WDATA`, `oAUD_OUT`, `oLEN`, `oDONE`, `oOVR`, `oSTATE`).
- All outputs registered; no combinational input-to-output path.
- **Record latency**: strobe sampled at edge E0; write asserted between E0 and E1; RAM writes at E1.
- **Playback latency**:
  - Strobe at E0; address valid after E0.
  - RAM registers the address at E1; data valid after E1.
  - `oAUD_OUT` updates at E2, i.e. 2 cycles after the strobe edge.
- `oDONE` is asserted in the cycle after the final write or load.
- Strobe spacing ≥ 3 cycles guarantees no `oOVR` (48 kHz frames give about 1000 cycles).

## Structure
- Package `audio_rec_pkg`:
  - state enum (IDLE/REC/PLAY/FETCH) with the encoding above
  - default `DW`/`DEPTH`/`AW` constants
- Single flat module; FSM plus one shared address counter.
- The RAM is `sample_ram` (DEPTH×DW, sync read), instantiated beside this block, not inside it.

## Test plan
- Record 5 strobes with `iAUD_IN` = 0x0101..0x0505, then `iSTOP`: RAM[0..4] hold those values, `oLEN`=5, no `oDONE`.
- Play with `iLOOP`=0 after the record above: `oAUD_OUT` steps 0x0101..0x0505, each 2 cycles after its strobe; `oDONE` after the 5th; `oAUD_OUT`=0 in IDLE.
- `iLOOP`=1, `oLEN`=3: 7 strobes give outputs 1,2,3,1,2,3,1; no `oDONE`; then `iSTOP` gives IDLE.
- Record DEPTH+3 strobes: last write at address 1999, `oDONE` once, `oLEN`=2000, extra strobes ignored.
- Boundary cases:
  - play `iSTART` with `oLEN`=0: stays IDLE
  - `iSTART`+`iSTOP` in the same cycle: IDLE
  - strobe in FETCH: `oOVR`=1
  - `iRST_N` low mid-REC: all outputs 0 immediately (async)
